// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment receive path: segment patterns
// (bit0 = a ... bit6 = g), decoded code constants and the dwell-state enum.
// Optional feature macro: SEG_SCAN_DP_EN (adds the decimal-point bit to seg_in).
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

`ifdef SEG_SCAN_DP_EN
    // Bit 7 carries the decimal point; it takes part in stability only.
    localparam int SEG_IN_W = 8;
`else
    localparam int SEG_IN_W = 7;
`endif

    // IDLE: no valid one-hot select; COUNT: qualifying a dwell; HELD: captured.
    typedef enum logic [1:0] {
        DW_IDLE  = 2'd0,
        DW_COUNT = 2'd1,
        DW_HELD  = 2'd2
    } dwell_state_t;

endpackage

// File: rtl/seg2bcd.sv
// Combinational seven-segment pattern to digit-code decoder.
// Digits 0..9 decode to their value, blank to CODE_BLANK, and every other
// pattern to CODE_ERR with o_invalid raised.
module seg2bcd
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_invalid
);

    // Pattern lookup; anything not in the table is an invalid pattern.
    always_comb begin
        o_code    = CODE_ERR;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = CODE_BLANK;
            default: begin
                o_code    = CODE_ERR;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive side of a multiplexed seven-segment display bus.
// Registers dig_sel/seg_in once, qualifies each digit dwell for stability
// (STABLE_CYCLES identical registered samples), decodes the captured pattern
// and presents a full frame once every digit position has been captured.
// Optional feature macro: SEG_SCAN_DP_EN (decimal point bit and dp_out).
module seg_scan_rx
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic [SEG_IN_W-1:0]   seg_in,
    output logic [4*DIGITS-1:0]   val_out,
    output logic                  val_valid,
    output logic                  err
`ifdef SEG_SCAN_DP_EN
    ,
    output logic [DIGITS-1:0]     dp_out
`endif
);

    // Count saturates at STABLE_CYCLES; capture fires on the step that reaches it.
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

    logic [DIGITS-1:0]   r_sel_p0;
    logic [SEG_IN_W-1:0] r_seg_p0;
    logic [DIGITS-1:0]   r_sel_p1;
    logic [SEG_IN_W-1:0] r_seg_p1;

    dwell_state_t        r_state;
    dwell_state_t        w_state_nxt;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic                w_capture;

    logic                w_onehot;
    logic                w_same;
    logic [3:0]          w_code;
    logic                w_invalid;

    logic [4*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_cap_mask;
    logic                r_frame_err;
    logic [DIGITS-1:0]   w_mask_all;
    logic                w_frame_done;
    logic [4*DIGITS-1:0] w_frame_val;

    // ---- stage p0/p1: registered sample and the sample before it ----

    // Register the bus once and keep the previous registered sample for comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_p0 <= '0;
            r_seg_p0 <= '0;
            r_sel_p1 <= '0;
            r_seg_p1 <= '0;
        end else begin
            r_sel_p0 <= dig_sel;
            r_seg_p0 <= seg_in;
            r_sel_p1 <= r_sel_p0;
            r_seg_p1 <= r_seg_p0;
        end
    end

    assign w_onehot = $onehot(r_sel_p0);
    assign w_same   = (r_sel_p0 == r_sel_p1) && (r_seg_p0 == r_seg_p1);

    // Single decoder on the registered segment lines; the DP bit is not decoded.
    seg2bcd u_seg2bcd (
        .i_seg     (r_seg_p0[6:0]),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    // ---- dwell qualification ----

    // Dwell state and stability count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DW_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next dwell state: a change restarts counting (one-hot) or drops to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            DW_IDLE: begin
                if (w_onehot) begin
                    w_state_nxt = DW_COUNT;
                    w_cnt_nxt   = 8'd1;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            DW_COUNT: begin
                if (w_same) begin
                    if (r_cnt >= CNT_CAP) begin
                        w_capture   = 1'b1;
                        w_state_nxt = DW_HELD;
                        w_cnt_nxt   = CNT_MAX;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end else if (w_onehot) begin
                    w_cnt_nxt   = 8'd1;
                end else begin
                    w_state_nxt = DW_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            DW_HELD: begin
                if (!w_same) begin
                    if (w_onehot) begin
                        w_state_nxt = DW_COUNT;
                        w_cnt_nxt   = 8'd1;
                    end else begin
                        w_state_nxt = DW_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = DW_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---- frame assembly ----

    // The registered select is one-hot whenever a capture fires, so it doubles
    // as the write-enable vector for the shadow slots.
    assign w_mask_all   = r_cap_mask | r_sel_p0;
    assign w_frame_done = w_capture && (&w_mask_all);

    // Completed frame value: shadow contents with the digit being captured now merged in.
    always_comb begin
        w_frame_val = r_shadow;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_sel_p0[i]) begin
                w_frame_val[4*i +: 4] = w_code;
            end
        end
    end

    // Shadow capture, capture mask, sticky frame error and the published frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_cap_mask  <= '0;
            r_frame_err <= 1'b0;
            val_out     <= '1;
            val_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            val_valid <= w_frame_done;
            if (w_capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (r_sel_p0[i]) begin
                        r_shadow[4*i +: 4] <= w_code;
                    end
                end
                if (w_frame_done) begin
                    val_out     <= w_frame_val;
                    err         <= r_frame_err | w_invalid;
                    r_cap_mask  <= '0;
                    r_frame_err <= 1'b0;
                end else begin
                    r_cap_mask  <= w_mask_all;
                    r_frame_err <= r_frame_err | w_invalid;
                end
            end
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [DIGITS-1:0] r_dp_shadow;
    logic [DIGITS-1:0] w_frame_dp;

    // Decimal points follow the same capture/merge path as the digit codes.
    always_comb begin
        w_frame_dp = r_dp_shadow;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_sel_p0[i]) begin
                w_frame_dp[i] = r_seg_p0[7];
            end
        end
    end

    // Decimal-point shadow and its published copy, updated together with val_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_shadow <= '0;
            dp_out      <= '0;
        end else if (w_capture) begin
            r_dp_shadow <= w_frame_dp;
            if (w_frame_done) begin
                dp_out <= w_frame_dp;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_rx.sv
// Self-checking bench for seg_scan_rx (DIGITS = 4, STABLE_CYCLES = 4).
// A dwell-level reference model predicts every frame; directed scenarios also
// check literal frame values.
module tb_seg_scan_rx;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;
`ifdef SEG_SCAN_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    dig_sel;
    logic [SW-1:0] seg_in;
    logic [15:0]   val_out;
    logic          val_valid;
    logic          err;
`ifdef SEG_SCAN_DP_EN
    logic [3:0]    dp_out;
`endif

    always #5 clk = ~clk;

    seg_scan_rx #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dig_sel   (dig_sel),
        .seg_in    (seg_in),
        .val_out   (val_out),
        .val_valid (val_valid),
        .err       (err)
`ifdef SEG_SCAN_DP_EN
        ,
        .dp_out    (dp_out)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder: every val_valid pulse is logged as {err, val_out} with its cycle.
    logic [16:0] got_q[$];
    int          got_cyc_q[$];
    int          dbl = 0;
    logic        prev_vld = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (val_valid === 1'b1) begin
                got_q.push_back({err, val_out});
                got_cyc_q.push_back(cyc);
                if (prev_vld) dbl++;
            end
            prev_vld = (val_valid === 1'b1);
        end else begin
            prev_vld = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    logic [6:0] pat [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111};

    logic [3:0]  m_sel;
    logic [6:0]  m_seg;
    int          m_len;
    bit          m_cap;
    logic [3:0]  m_code [0:3];
    logic [3:0]  m_mask;
    bit          m_ferr;
    logic [16:0] exp_q[$];

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        if (s == 7'd0) return 4'hF;
        for (int i = 0; i < 10; i++) if (pat[i] == s) return 4'(i);
        return 4'hE;
    endfunction

    task automatic model_reset();
        m_sel = '0; m_seg = '0; m_len = 0; m_cap = 1'b1;
        m_mask = '0; m_ferr = 1'b0;
        for (int i = 0; i < 4; i++) m_code[i] = 4'h0;
    endtask

    // A run of identical bus values of total length >= STABLE with a one-hot
    // select captures its digit exactly once.
    task automatic model_dwell(input logic [3:0] sel, input logic [6:0] seg, input int len);
        logic [3:0] c;
        if (sel != m_sel || seg != m_seg) begin
            m_sel = sel; m_seg = seg; m_len = 0; m_cap = 1'b0;
        end
        m_len += len;
        if (!m_cap && m_len >= STABLE && $countones(sel) == 1) begin
            m_cap = 1'b1;
            c = ref_decode(seg);
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    m_code[i] = c;
                    m_mask[i] = 1'b1;
                end
            end
            if (c == 4'hE) m_ferr = 1'b1;
            if (m_mask == 4'hF) begin
                exp_q.push_back({m_ferr, m_code[3], m_code[2], m_code[1], m_code[0]});
                m_mask = '0;
                m_ferr = 1'b0;
            end
        end
    endtask

    // Drive one dwell starting at a falling edge; lasts len sampling edges.
    task automatic dwell(input logic [3:0] sel, input logic [6:0] seg, input int len);
        dig_sel = sel;
        seg_in  = SW'(seg);
        model_dwell(sel, seg, len);
        repeat (len) @(negedge clk);
    endtask

    task automatic settle();
        dwell(4'b0000, 7'd0, 6);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; dig_sel = '0; seg_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (val_out !== 16'hFFFF) begin n_fail++; $display("FAIL reset_val_out: got %h want ffff", val_out); end
        n_checks++;
        if (val_valid !== 1'b0) begin n_fail++; $display("FAIL reset_val_valid: got %b want 0", val_valid); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int c0;
        for (int d = 0; d < 3; d++) dwell(4'(1 << d), pat[d+1], 6);
        c0 = cyc;
        dwell(4'b1000, pat[4], 6);
        settle();
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== {1'b0, 16'h4321}) begin n_fail++; $display("FAIL basic_frame: got %h want 04321", got_q[0]); end
            n_checks++;
            if (got_cyc_q[0] != c0 + 1 + STABLE) begin n_fail++; $display("FAIL basic_latency: got cycle %0d want %0d", got_cyc_q[0], c0 + 1 + STABLE); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++;
        if (val_out !== 16'h4321 || err !== 1'b0) begin n_fail++; $display("FAIL basic_hold: got %h/%b want 4321/0", val_out, err); end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_invalid();
        dwell(4'b0001, pat[5], 6);
        dwell(4'b0010, pat[6], 6);
        dwell(4'b0100, 7'b0101010, 6);
        dwell(4'b1000, pat[8], 6);
        settle();
        dwell(4'b0001, pat[9], 6);
        dwell(4'b0010, pat[0], 6);
        dwell(4'b0100, pat[1], 6);
        dwell(4'b1000, pat[2], 6);
        settle();
        n_checks++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL invalid_pulses: got %0d want 2", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== {1'b1, 16'h8E65}) begin n_fail++; $display("FAIL invalid_frame: got %h want 18e65", got_q[0]); end
            n_checks++;
            if (got_q[1] !== {1'b0, 16'h2109}) begin n_fail++; $display("FAIL invalid_clean: got %h want 02109", got_q[1]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL invalid_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_short_dwell();
        dwell(4'b0001, pat[7], 5);
        dwell(4'b0010, pat[8], 3);
        dwell(4'b0100, pat[9], 5);
        dwell(4'b1000, pat[0], 5);
        settle();
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL short_no_pulse: got %0d want 0", got_q.size()); end
        dwell(4'b0010, pat[8], 4);
        settle();
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL short_pulses: got %0d want 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== {1'b0, 16'h0987}) begin n_fail++; $display("FAIL short_frame: got %h want 00987", got_q[0]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL short_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_multihot();
        dwell(4'b0001, pat[1], 5);
        dwell(4'b0010, pat[2], 5);
        dwell(4'b0100, pat[3], 5);
        dwell(4'b0011, pat[5], 10);
        settle();
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL multihot_no_pulse: got %0d want 0", got_q.size()); end
        dwell(4'b1000, pat[4], 5);
        settle();
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL multihot_pulses: got %0d want 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== {1'b0, 16'h4321}) begin n_fail++; $display("FAIL multihot_frame: got %h want 04321", got_q[0]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL multihot_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_overwrite();
        dwell(4'b0001, pat[5], 5);
        dwell(4'b0001, pat[7], 5);
        dwell(4'b0010, pat[1], 5);
        dwell(4'b0100, pat[1], 5);
        dwell(4'b1000, pat[1], 5);
        settle();
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL overwrite_pulses: got %0d want 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== {1'b0, 16'h1117}) begin n_fail++; $display("FAIL overwrite_frame: got %h want 01117", got_q[0]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL overwrite_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        dwell(4'b0001, pat[3], 5);
        dwell(4'b0010, pat[3], 5);
        dwell(4'b0100, pat[3], 5);
        rst_n = 1'b0; dig_sel = '0; seg_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (val_out !== 16'hFFFF || val_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h/%b/%b want ffff/0/0", val_out, val_valid, err);
        end
        rst_n = 1'b1;
        model_reset();
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
        dwell(4'b1000, pat[6], 5);
        settle();
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL midreset_no_pulse: got %0d want 0", got_q.size()); end
        dwell(4'b0001, pat[2], 5);
        dwell(4'b0010, pat[2], 5);
        dwell(4'b0100, pat[2], 5);
        settle();
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL midreset_pulses: got %0d want 1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== {1'b0, 16'h6222}) begin n_fail++; $display("FAIL midreset_frame: got %h want 06222", got_q[0]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [3:0] sel;
        logic [6:0] seg;
        int a, b, r;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            a = int'($urandom_range(0, 3));
            if (r == 7) sel = 4'b0000;
            else if (r == 8) begin
                b = (a + 1 + int'($urandom_range(0, 2))) % 4;
                sel = 4'(1 << a) | 4'(1 << b);
            end else sel = 4'(1 << a);
            r = int'($urandom_range(0, 11));
            if (r < 10) seg = pat[r];
            else if (r == 10) seg = 7'd0;
            else seg = 7'($urandom);
            dwell(sel, seg, int'($urandom_range(1, 7)));
        end
        settle();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_pulses: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
    endtask

    task automatic test_pulse_width();
        n_checks++;
        if (dbl != 0) begin n_fail++; $display("FAIL pulse_width: got %0d back-to-back pulses want 0", dbl); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_invalid();
        test_short_dwell();
        test_multihot();
        test_overwrite();
        test_reset_mid();
        test_random();
        test_pulse_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_rx.md
# seg_scan_rx

Receive side of the multiplexed seven-segment display bus. Snoops the time-multiplexed digit-select and segment lines driven to the display, qualifies each digit dwell for stability, and decodes segment patterns back to 4-bit digit codes. Once every digit position has been captured, it presents one full frame as a parallel value. It sits beside the display driver and is used for self-check and for read-back of the displayed value.

## Interface
- `DIGITS`, default 4: number of multiplexed digit positions.
- `STABLE_CYCLES`, default 4, legal range 2..255: consecutive identical registered samples required before a digit is accepted.
- `clk`  in  1  single clock; all inputs synchronous to it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dig_sel`  in  DIGITS  digit enable, active-high, one-hot when valid.
- `seg_in`  in  7  segment lines, active-high; bit0 = a … bit6 = g.
- `val_out`  out  4*DIGITS  last complete frame; digit i occupies bits [4i+3:4i].
- `val_valid`  out  1  one-cycle pulse when `val_out` updates.
- `err`  out  1  held with each frame; 1 if any digit in that frame decoded as invalid.

## Operation
- Decode patterns (g..a):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - blank 0000000 → 4'hF, no error
  - any other pattern → 4'hE, and flags an error for the frame
- Input stage: `dig_sel` and `seg_in` are registered once. All qualification uses the registered samples together with the previous registered sample.
- Dwell FSM, states IDLE, COUNT, HELD:
  - IDLE: the registered `dig_sel` is not one-hot (zero or multi-hot). Count is cleared and nothing is captured.
  - IDLE → COUNT: a one-hot sample arrives; count = 1.
  - COUNT, sample identical to the previous one (`dig_sel` and `seg_in`): count increments. When count reaches `STABLE_CYCLES`, the decoded code is written to `shadow[idx]`, `cap_mask[idx]` is set, an invalid pattern sets `frame_err`, and the FSM moves to HELD.
  - COUNT, sample differs: stay in COUNT with count = 1 if the new sample is one-hot, otherwise go to IDLE.
  - HELD: stay while the sample is unchanged; no recapture. Any change follows the same rules as a differing sample in COUNT.
- Recapture of a position already in `cap_mask`: the newer code overwrites the older one. `frame_err` stays ORed.
- Frame completion: on the edge where a capture makes `cap_mask` all-ones (counting the current capture):
  - `val_out` is loaded from `shadow`, with the current digit merged in.
  - `err` is set to `frame_err` OR the current digit's error.
  - `val_valid` pulses high.
  - `cap_mask` and `frame_err` clear.
- Digits may arrive in any order.
- Count saturates at `STABLE_CYCLES`.

## Timing
- Reset values: `val_out` = all-ones (every digit 4'hF), `val_valid` = 0, `err` = 0; FSM in IDLE; count, `cap_mask`, `frame_err` and `shadow` cleared.
- Latency: with a pattern first present at the ports in cycle 0, the capture occurs at edge `STABLE_CYCLES`. If it completes a frame, `val_valid` is high in the cycle immediately after that edge.
- Minimum accepted dwell: `STABLE_CYCLES` cycles. Shorter dwells are ignored completely.
- `val_valid` is never high for two consecutive cycles. `val_out` and `err` hold between pulses.
- Reset asserted mid-frame discards all partial captures; no pulse follows on release.

## Configuration
- `SEG_SCAN_DP_EN`:
  - Defined: `seg_in` widens to 8 bits, with bit7 = decimal point. The DP is excluded from decoding but included in the stability compare. Adds output `dp_out [DIGITS-1:0]`, reset 0 and updated with `val_out`.
  - Undefined: `seg_in` is 7 bits and there is no `dp_out`.

## Structure
- Shared package `seg_pkg`:
  - segment constants `SEG_0`..`SEG_9` and `SEG_BLANK`
  - code constants `CODE_BLANK` = 4'hF and `CODE_ERR` = 4'hE
  - the dwell-state enum
- Sub-module `seg2bcd`: combinational pattern → {code, invalid}. It is instantiated once, on the registered `seg_in`.

## Test plan
- Dwell 6 cycles per digit, `STABLE_CYCLES` = 4, digits 0..3 showing patterns for 1, 2, 3, 4 → one `val_valid` pulse; `val_out` = 16'h4321, `err` = 0.
- Digit 2 shows 0101010, others valid → `val_out[11:8]` = 4'hE, `err` = 1; next clean frame → `err` = 0.
- Digit 1 dwell of 3 cycles, then proper dwells → short dwell not captured; pulse only after a full 4-cycle dwell of digit 1.
- `dig_sel` = 4'b0011 held for 10 cycles → no capture and no pulse; `cap_mask` unchanged.
- Digit 0 captured as 5 then 7 within the same frame, frame completes → `val_out[3:0]` = 4'h7.
- `rst_n` low after 3 of 4 digits captured, then a full frame → outputs read all-ones/0/0 during reset; exactly one pulse, after all 4 digits are re-captured.
